run_ctrl: RTL and testbench
===========================

# run_ctrl

Host-side run controller for the 9-bit basic processor: the initiator end of the core's `start`/`halt` handshake and the writer of its instruction memory. It accepts a program as a valid/ready stream of 9-bit words and writes them into a writable instruction RAM. It then pulses `start` into the core and waits for `halt`. While the core runs it counts cycles, with an optional timeout. It sits between the test harness or host port and the processor top level.

## Interface
- `IW`, 9, instruction word width
- `AW`, 10, instruction address width (matches the 10-bit PC)
- `CW`, 16, cycle counter width
- `START_CYC`, 2, number of cycles `start` is held high (must be ≥1)

- `CLK` in 1: clock, posedge
- `reset` in 1: asynchronous, active-high reset
- `load_valid` in 1: program word valid
- `load_ready` out 1: controller can accept a word
- `load_data` in IW: program word
- `load_last` in 1: marks final word of the program
- `imem_we` out 1: instruction RAM write enable
- `imem_addr` out AW: instruction RAM write address
- `imem_wdata` out IW: instruction RAM write data
- `go` in 1: request a run of the loaded program
- `start` out 1: to core `start` (init, active high)
- `halt` in 1: from core, done flag
- `timeout_cycles` in CW: run limit; 0 disables the limit
- `busy` out 1: high in START or RUN
- `done` out 1: high in DONE
- `timed_out` out 1: last run ended by timeout
- `load_err` out 1: last load overflowed the address space
- `prog_len` out AW+1: number of words in the last completed load
- `cycle_count` out CW: run cycles of the current or last run

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- `load_ready` = 1 in IDLE, LOAD and DONE; 0 in START and RUN.
- Handshake: a word is accepted when `load_valid && load_ready`.
  - `load_data` and the write pointer are registered onto `imem_wdata`/`imem_addr` with `imem_we`=1 for exactly one cycle.
  - The write pointer then increments.
- First accept in IDLE or DONE:
  - pointer starts at 0;
  - `done`, `timed_out`, `load_err` are cleared;
  - state goes to LOAD, or stays in IDLE if that same word has `load_last`=1.
- Accept with `load_last`=1: `prog_len` = pointer+1; state goes to IDLE.
- Accept at address 2^AW−1 without `load_last`:
  - the word is written and treated as last;
  - `load_err`=1 and `prog_len`=2^AW;
  - state goes to IDLE.
- `go` behaviour:
  - ignored in LOAD, START and RUN;
  - in IDLE, honoured only if `prog_len`≠0;
  - in DONE, honoured always (reruns the same program);
  - `go` and an accepted word in the same cycle in IDLE/DONE: the load wins and `go` is dropped.
- START:
  - `cycle_count`, `done` and `timed_out` are cleared on entry;
  - `start`=1 for exactly START_CYC cycles;
  - `halt` is ignored here (the core's `halt` is invalid during init);
  - then state goes to RUN.
- RUN:
  - each clock with `halt`=0, `cycle_count` increments, saturating at 2^CW−1;
  - `halt`=1: go to DONE with `timed_out`=0 and no increment on that edge;
  - if `timeout_cycles`≠0 and the incremented count equals `timeout_cycles`: go to DONE with `timed_out`=1;
  - `halt` and timeout in the same cycle: `halt` wins.
- DONE: `done`=1 and `cycle_count` is frozen until the next START entry or load.
- Reset at any time, including mid-load or mid-run:
  - state goes to IDLE and the run is abandoned;
  - `start` drops asynchronously;
  - `prog_len`=0.

## Timing
- Reset values: state IDLE; `load_ready`=1; all other outputs 0.
- Accept edge → `imem_we`/`imem_addr`/`imem_wdata` valid for one cycle, starting the following cycle (1-cycle latency).
- Sustained `load_valid` gives one word per cycle, with no bubbles.
- `go` sampled at edge N:
  - `start` high from cycle N+1 through N+START_CYC;
  - RUN from cycle N+START_CYC+1.
- `halt` sampled in RUN at edge M → `done`=1 and `busy`=0 from cycle M+1.
- Every status output is a register output or a pure decode of state; none is combinational from inputs.

## Test plan
- Load 3 words 0x1A0, 0x0FF, 0x101 (last on the third), back-to-back:
  - `imem_we` pulses at addr 0, 1, 2 with matching data;
  - `prog_len`=3; `load_err`=0.
- With `START_CYC`=2, pulse `go`, then raise `halt` 10 cycles after RUN entry:
  - `start` high for exactly 2 cycles;
  - `cycle_count`=10; `done`=1; `timed_out`=0.
- Set `timeout_cycles`=5 and never raise `halt` → `cycle_count`=5, `done`=1, `timed_out`=1.
- Drive `halt` high during START and `go` during RUN → both ignored; no early DONE.
- Load 1024 words without `load_last` → last write at addr 0x3FF; `load_err`=1; `prog_len`=1024; state IDLE.
- Assert `reset` mid-RUN → `start`=0 and `busy`=0 immediately; `prog_len`=0; a subsequent `go` is ignored.

Source files
------------

// File: rtl/run_ctrl.sv
// ============================================================================
//  Module   : run_ctrl
//  Purpose  : Host-side run controller: loads the instruction RAM from a
//             valid/ready stream, then starts the core and times its run.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module run_ctrl #(
   parameter int IW        = 9,
   parameter int AW        = 10,
   parameter int CW        = 16,
   parameter int START_CYC = 2
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [IW-1:0]   load_data,
   input  logic            load_last,
   output logic            imem_we,
   output logic [AW-1:0]   imem_addr,
   output logic [IW-1:0]   imem_wdata,
   input  logic            go,
   output logic            start,
   input  logic            halt,
   input  logic [CW-1:0]   timeout_cycles,
   output logic            busy,
   output logic            done,
   output logic            timed_out,
   output logic            load_err,
   output logic [AW:0]     prog_len,
   output logic [CW-1:0]   cycle_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int            c_SCW        = (START_CYC > 1) ? $clog2(START_CYC) : 1;
   localparam logic [c_SCW-1:0] c_START_LAST = c_SCW'(START_CYC - 1);
   localparam logic [AW-1:0] c_ADDR_MAX   = {AW{1'b1}};

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [AW-1:0]    r_ptr;
   logic [c_SCW-1:0] r_start_cnt;

   logic             w_accept;
   logic             w_first;
   logic [AW-1:0]    w_addr;
   logic             w_last_eff;
   logic             w_overflow;
   logic [CW-1:0]    w_cnt_inc;
   logic             w_tmo_hit;
   logic             w_enter_start;

   // A word arriving in IDLE/DONE always begins a fresh program at address 0.
   assign w_accept      = load_valid && load_ready;
   assign w_first       = (r_state != S_LOAD);
   assign w_addr        = w_first ? '0 : r_ptr;
   assign w_overflow    = (w_addr == c_ADDR_MAX) && !load_last;
   assign w_last_eff    = load_last || (w_addr == c_ADDR_MAX);
   assign w_cnt_inc     = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
   assign w_tmo_hit     = (timeout_cycles != '0) && (w_cnt_inc == timeout_cycles);
   assign w_enter_start = (r_state != S_START) && (w_state_nxt == S_START);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_last_eff ? S_IDLE : S_LOAD;
            end else if (go && (prog_len != '0)) begin
               w_state_nxt = S_START;
            end
         end
         S_LOAD: begin
            if (w_accept && w_last_eff) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_START: begin
            if (r_start_cnt == c_START_LAST) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // halt takes priority over a coincident timeout
            if (halt || w_tmo_hit) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (w_accept) begin
               w_state_nxt = w_last_eff ? S_IDLE : S_LOAD;
            end else if (go) begin
               w_state_nxt = S_START;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      start      = 1'b0;
      case (r_state)
         S_IDLE:  load_ready = 1'b1;
         S_LOAD:  load_ready = 1'b1;
         S_START: begin
            busy  = 1'b1;
            start = 1'b1;
         end
         S_RUN:   busy = 1'b1;
         S_DONE: begin
            load_ready = 1'b1;
            done       = 1'b1;
         end
         default: load_ready = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_start_cnt <= '0;
      end else if (r_state != S_START) begin
         r_start_cnt <= '0;
      end else begin
         r_start_cnt <= r_start_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         r_ptr      <= '0;
         prog_len   <= '0;
         load_err   <= 1'b0;
         timed_out  <= 1'b0;
         cycle_count <= '0;
      end else begin
         imem_we <= w_accept;
         if (w_accept) begin
            imem_addr  <= w_addr;
            imem_wdata <= load_data;
            r_ptr      <= w_addr + 1'b1;
            if (w_first) begin
               timed_out   <= 1'b0;
               load_err    <= 1'b0;
               cycle_count <= '0;
            end
            if (w_last_eff) begin
               prog_len <= {1'b0, w_addr} + {{AW{1'b0}}, 1'b1};
               load_err <= w_overflow;
            end
         end
         if (w_enter_start) begin
            cycle_count <= '0;
            timed_out   <= 1'b0;
         end
         if ((r_state == S_RUN) && !halt) begin
            cycle_count <= w_cnt_inc;
            if (w_tmo_hit) begin
               timed_out <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// ============================================================================
//  Module   : tb_run_ctrl
//  Purpose  : Self-checking bench for run_ctrl: vector table, directed corner
//             sequences and random traffic against a behavioural model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_run_ctrl;

   localparam int IW        = 9;
   localparam int AW        = 10;
   localparam int CW        = 16;
   localparam int START_CYC = 2;

   logic          CLK = 1'b0;
   logic          reset = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [IW-1:0] load_data = '0;
   logic          load_last = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;
   logic          go = 1'b0;
   logic          start;
   logic          halt = 1'b0;
   logic [CW-1:0] timeout_cycles = '0;
   logic          busy;
   logic          done;
   logic          timed_out;
   logic          load_err;
   logic [AW:0]   prog_len;
   logic [CW-1:0] cycle_count;

   run_ctrl #(.IW(IW), .AW(AW), .CW(CW), .START_CYC(START_CYC)) dut (
      .CLK(CLK), .reset(reset),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .go(go), .start(start), .halt(halt),
      .timeout_cycles(timeout_cycles), .busy(busy), .done(done),
      .timed_out(timed_out), .load_err(load_err), .prog_len(prog_len),
      .cycle_count(cycle_count)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Behavioural model: a run is "starting" while start cycles remain,
   // "running" until halt/timeout, "finished" until the next load or go.
   bit            m_loading, m_running, m_done;
   int            m_sleft, m_ptr;
   logic          e_we, e_tmo, e_lerr;
   logic [AW-1:0] e_addr;
   logic [IW-1:0] e_wd;
   logic [AW:0]   e_plen;
   logic [CW-1:0] e_cnt;

   task automatic m_reset();
      m_loading = 0; m_running = 0; m_done = 0; m_sleft = 0; m_ptr = 0;
      e_we = 0; e_tmo = 0; e_lerr = 0; e_addr = '0; e_wd = '0; e_plen = '0; e_cnt = '0;
   endtask

   task automatic m_step();
      int a;
      bit busy_now;
      busy_now = (m_sleft > 0) || m_running;
      e_we = 0;
      if (load_valid && !busy_now) begin
         a = m_loading ? m_ptr : 0;
         if (!m_loading) begin
            m_done = 0; e_tmo = 0; e_lerr = 0; e_cnt = '0;
         end
         e_we = 1; e_addr = AW'(a); e_wd = load_data; m_ptr = a + 1;
         if (load_last || a == (1 << AW) - 1) begin
            e_plen = (AW+1)'(a + 1);
            e_lerr = !load_last;
            m_loading = 0;
         end else begin
            m_loading = 1;
         end
      end else if (m_sleft > 0) begin
         m_sleft--;
         if (m_sleft == 0) m_running = 1;
      end else if (m_running) begin
         if (halt) begin
            m_running = 0; m_done = 1;
         end else begin
            if (e_cnt != {CW{1'b1}}) e_cnt = e_cnt + 1'b1;
            if (timeout_cycles != 0 && e_cnt == timeout_cycles) begin
               m_running = 0; m_done = 1; e_tmo = 1;
            end
         end
      end else if (go && !m_loading && (m_done || e_plen != 0)) begin
         m_sleft = START_CYC; e_cnt = '0; e_tmo = 0; m_done = 0;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_model();
      logic [63:0] act, exp;
      bit mb;
      mb  = (m_sleft > 0) || m_running;
      act = {11'd0, load_ready, imem_we, imem_addr, imem_wdata, start, busy, done,
             timed_out, load_err, prog_len, cycle_count};
      exp = {11'd0, !mb, e_we, e_addr, e_wd, (m_sleft > 0), mb, m_done,
             e_tmo, e_lerr, e_plen, e_cnt};
      chk("model", act, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      if (reset) m_reset(); else m_step();
      @(negedge CLK);
      check_model();
   endtask

   typedef struct {
      logic          lv, ll, g;
      logic [IW-1:0] ld;
      logic          e_we, e_start, e_busy;
      logic [AW-1:0] e_addr;
      logic [IW-1:0] e_wd;
      logic [AW:0]   e_plen;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1, 0, 0, 9'h1A0, 1, 0, 0, 10'd0, 9'h1A0, 11'd0};
      tbl[1] = '{1, 0, 0, 9'h0FF, 1, 0, 0, 10'd1, 9'h0FF, 11'd0};
      tbl[2] = '{1, 1, 0, 9'h101, 1, 0, 0, 10'd2, 9'h101, 11'd3};
      tbl[3] = '{0, 0, 1, 9'h000, 0, 1, 1, 10'd2, 9'h101, 11'd3};
      tbl[4] = '{0, 0, 0, 9'h000, 0, 1, 1, 10'd2, 9'h101, 11'd3};
      tbl[5] = '{0, 0, 0, 9'h000, 0, 0, 1, 10'd2, 9'h101, 11'd3};

      m_reset();
      reset = 1'b1;
      #12;
      chk("rst_outs", {load_ready, imem_we, start, busy, done, timed_out, load_err},
          7'b1000000);
      chk("rst_vals", {prog_len, cycle_count}, '0);
      @(negedge CLK);
      reset = 1'b0;
      tick();

      // Back-to-back three-word load, then go and the start pulse
      for (int i = 0; i < 6; i++) begin
         load_valid = tbl[i].lv; load_last = tbl[i].ll; load_data = tbl[i].ld; go = tbl[i].g;
         tick();
         chk($sformatf("vec%0d", i),
             {imem_we, start, busy, imem_addr, imem_wdata, prog_len},
             {tbl[i].e_we, tbl[i].e_start, tbl[i].e_busy, tbl[i].e_addr, tbl[i].e_wd,
              tbl[i].e_plen});
      end
      chk("load_err3", load_err, 0);

      // Halt 10 cycles after RUN entry
      for (int i = 0; i < 10; i++) tick();
      chk("run10", {busy, done, cycle_count}, {2'b10, 16'd10});
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_done", {busy, done, timed_out, cycle_count}, {3'b010, 16'd10});

      // Rerun from DONE with timeout 5; halt in START and go in RUN are ignored
      timeout_cycles = 16'd5;
      go = 1'b1;
      tick();
      chk("rerun_start", {start, busy, done, cycle_count}, {3'b110, 16'd0});
      go = 1'b0; halt = 1'b1;
      tick();
      chk("halt_in_start", {start, busy, done}, 3'b110);
      tick();
      chk("run_entry", {start, busy, done, cycle_count}, {3'b010, 16'd0});
      halt = 1'b0; go = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("go_in_run", {busy, done, cycle_count}, {2'b10, 16'd4});
      tick();
      go = 1'b0;
      chk("timeout", {busy, done, timed_out, cycle_count}, {3'b011, 16'd5});
      timeout_cycles = '0;

      // 1024 words without last: wraps to the top address and flags overflow
      load_valid = 1'b1; load_last = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         load_data = IW'($urandom);
         tick();
         if (i == 0) chk("load_clears", {done, timed_out, cycle_count}, '0);
      end
      load_valid = 1'b0;
      chk("ovf_addr", {imem_we, imem_addr}, {1'b1, 10'h3FF});
      chk("ovf_flags", {load_err, prog_len, load_ready, busy}, {1'b1, 11'd1024, 2'b10});
      tick();

      // Asynchronous reset in the middle of a run
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst_run", {busy, start}, 2'b10);
      #2 reset = 1'b1;
      #1;
      chk("async_rst", {start, busy, prog_len}, '0);
      m_reset();
      tick();
      reset = 1'b0;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("go_after_rst", {start, busy}, 2'b00);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         load_valid = ($urandom_range(0, 2) == 0);
         load_last  = ($urandom_range(0, 7) == 0);
         load_data  = IW'($urandom);
         go         = ($urandom_range(0, 5) == 0);
         halt       = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 49) == 0)
            timeout_cycles = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(1, 20));
         reset = ($urandom_range(0, 599) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
